// File: rtl/qoa_spi_pkg.sv
// Shared types and constants for the QOA host-link SPI slave.
// FSM state encoding, SPI mode constants, default synchroniser depth.
package qoa_spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int CPOL_IDLE_LOW  = 0;
  localparam int CPOL_IDLE_HIGH = 1;
  localparam int CPHA_LEAD      = 0;
  localparam int CPHA_TRAIL     = 1;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/qoa_spi_sync_edge.sv
// Multi-stage synchroniser with registered rise/fall pulses.
// Ports: clk, rst_n, i_d (async pin), o_rise, o_fall (1-clk pulses).
module qoa_sync_edge
  import qoa_spi_pkg::*;
#(
  parameter int   STAGES  = SYNC_STAGES_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;
  logic              w_q;

  assign w_q    = r_sync[STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= w_q;
      r_rise <= w_q & ~r_prev;
      r_fall <= ~w_q & r_prev;
    end
  end

endmodule

// File: rtl/qoa_spi_slave.sv
// Oversampled single-clock SPI slave, all four modes, RX valid/ready,
// one-entry TX buffer. Ports: SPI pins, rx_*, tx_*, busy_o.
module qoa_spi_slave
  import qoa_spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = CPOL_IDLE_LOW,
  parameter int CPHA        = CPHA_LEAD,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              rx_overrun_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_underrun_o,
  output logic              busy_o
);

  localparam int CW =
    ($clog2(DATA_W) > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  localparam logic LP_IDLE  = (CPOL != 0);
  localparam logic LP_CPHA1 = (CPHA != 0);

  state_e            r_state;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic [DATA_W-1:0] r_tx_buf;
  logic [CW-1:0]     r_bit_cnt;
  logic              r_rx_valid;
  logic              r_rx_ovr;
  logic              r_tx_full;
  logic              r_tx_udr;
  logic              r_reload_pend;
  logic              r_first;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_lead;
  logic w_trail;
  logic w_sample;
  logic w_shift;
  logic w_done;
  logic w_reload;
  logic w_mosi;
  logic w_tx_wr;
  logic w_rx_rd;

  qoa_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (LP_IDLE)
  ) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (sclk_i),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  qoa_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (cs_n_i),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
  assign w_lead   = LP_IDLE ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = LP_IDLE ? w_sclk_rise : w_sclk_fall;
  assign w_sample = LP_CPHA1 ? w_trail : w_lead;
  assign w_shift  = LP_CPHA1 ? w_lead : w_trail;
  assign w_done   = w_sample && (r_bit_cnt == LAST);
  assign w_tx_wr  = tx_valid_i && !r_tx_full;
  assign w_rx_rd  = r_rx_valid && rx_ready_i;

  // CPHA=0 reloads on the first shift edge after a word, CPHA=1 on
  // the sample edge that completes it; both reload at cs_n assert.
  assign w_reload = (r_state == ST_IDLE) ? w_cs_fall :
    (!w_cs_rise && (LP_CPHA1 ? w_done : (w_shift && r_reload_pend)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_tx_buf      <= '0;
      r_bit_cnt     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_ovr      <= 1'b0;
      r_tx_full     <= 1'b0;
      r_tx_udr      <= 1'b0;
      r_reload_pend <= 1'b0;
      r_first       <= 1'b0;
    end else begin
      r_rx_ovr <= 1'b0;
      r_tx_udr <= 1'b0;
      if (w_tx_wr) begin
        r_tx_buf  <= tx_data_i;
        r_tx_full <= 1'b1;
      end
      if (w_rx_rd) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state       <= ST_ACTIVE;
            r_bit_cnt     <= '0;
            r_first       <= 1'b1;
            r_reload_pend <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state       <= ST_IDLE;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_reload_pend <= 1'b0;
            r_first       <= 1'b0;
          end else begin
            if (w_sample) begin
              r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi};
              r_bit_cnt  <= w_done ? '0 : r_bit_cnt + 1'b1;
              if (w_done) begin
                if (!r_rx_valid || rx_ready_i) begin
                  r_rx_data  <= {r_rx_shift[DATA_W-2:0], w_mosi};
                  r_rx_valid <= 1'b1;
                end else begin
                  r_rx_ovr <= 1'b1;
                end
                if (LP_CPHA1) begin
                  r_first <= 1'b1;
                end else begin
                  r_reload_pend <= 1'b1;
                end
              end
            end
            if (w_shift) begin
              if (!LP_CPHA1 && r_reload_pend) begin
                r_reload_pend <= 1'b0;
              end else if (LP_CPHA1 && r_first) begin
                // keep the MSB on miso through the first sample
                r_first <= 1'b0;
              end else begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_reload) begin
        if (r_tx_full) begin
          r_tx_shift <= r_tx_buf;
          r_tx_full  <= 1'b0;
        end else begin
          r_tx_shift <= '0;
          r_tx_udr   <= 1'b1;
        end
      end
    end
  end

  assign miso_o        = r_tx_shift[DATA_W-1];
  assign miso_oe_o     = (r_state == ST_ACTIVE);
  assign busy_o        = (r_state == ST_ACTIVE);
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;
  assign rx_overrun_o  = r_rx_ovr;
  assign tx_ready_o    = ~r_tx_full;
  assign tx_underrun_o = r_tx_udr;

endmodule

// File: doc/qoa_spi_slave.md
Name: qoa_spi_slave

Overview:
Parametrised, fully synchronous SPI slave for the QOA decoder host link. It replaces the dual-domain shifter with oversampling: sclk, cs_n and mosi are synchronised into clk and edge-detected, so all state lives in one clock domain. It supports all four SPI modes, a configurable word width, a valid/ready RX port and a one-entry TX buffer with underrun/overrun reporting. It sits between the uio pins and the decoder's sample/command logic.

Parameters:
DATA_W, 8, SPI word width in bits (>=2), MSB first
CPOL, 0, idle level of sclk
CPHA, 0, 0 = sample on leading edge / shift on trailing; 1 = shift on leading / sample on trailing
SYNC_STAGES, 2, synchroniser depth for sclk/cs_n/mosi (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
sclk_i  in  1  SPI clock pin (asynchronous)
cs_n_i  in  1  chip select pin, active-low (asynchronous)
mosi_i  in  1  host-to-slave data pin
miso_o  out  1  slave-to-host data
miso_oe_o  out  1  output enable for miso pad
rx_data_o  out  DATA_W  received word
rx_valid_o  out  1  rx_data_o holds an unread word
rx_ready_i  in  1  consumer accepts word (transfer when valid&ready)
rx_overrun_o  out  1  1-cycle pulse: completed word dropped
tx_data_i  in  DATA_W  next word to transmit
tx_valid_i  in  1  tx_data_i offered
tx_ready_o  out  1  TX buffer empty (write when valid&ready)
tx_underrun_o  out  1  1-cycle pulse: word reload with buffer empty
busy_o  out  1  chip selected (synchronised)

Behaviour:
- Reset (async, rst_n low): sync chains preset to idle (sclk=CPOL, cs_n=1, mosi=0); all outputs 0, except tx_ready_o=1; shift registers and bit counter 0; FSM IDLE.
- Edge detect on the synced sclk: leading = departure from CPOL, trailing = return. Sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
- FSM IDLE: miso_oe_o=0, miso_o=0. On synced cs_n falling, go to ACTIVE, clear the bit counter and do a word reload.
- FSM ACTIVE: miso_oe_o=1, miso_o=tx_shift[DATA_W-1]. On synced cs_n rising, go to IDLE from any bit position. A partial RX word is discarded and no rx_valid is raised. The TX shift content is dropped; the buffered TX word is kept.
- Word reload:
  - If the TX buffer is full, load it into tx_shift and empty the buffer (tx_ready_o=1 next cycle).
  - Otherwise load 0 and pulse tx_underrun_o.
  - A tx write in the same cycle as an empty-buffer reload is still an underrun; the write fills the buffer for the following word.
- Sample edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}, and the bit counter increments (wraps at DATA_W-1 -> 0). On the edge completing bit DATA_W-1:
  - If the holding register is empty, or is being read in the same cycle, write the word into it and set rx_valid_o next cycle.
  - Else keep the old word and pulse rx_overrun_o.
- Shift edge: tx_shift shifts left with zero fill, with these exceptions:
  - CPHA=0: the first shift edge after a completed word performs a word reload instead of a shift.
  - CPHA=1: the reload happens on the sample edge completing a word. The first shift edge of every word (including right after cs_n assert) is suppressed, so the MSB stays valid through the first sample.
- Latency: pin edge to internal event = SYNC_STAGES+1 clk. rx_valid_o rises SYNC_STAGES+2 clk after the final pin sample edge. Required f_clk >= 2*(SYNC_STAGES+2)*f_sclk (8x at default).
- Bit counter width is max(1,$clog2(DATA_W)). No arithmetic beyond counter increment.

Decomposition:
- Package qoa_spi_pkg: FSM state typedef (IDLE, ACTIVE), CPHA/CPOL mode localparams, and the default SYNC_STAGES constant.
- Sub-module qoa_sync_edge: SYNC_STAGES-deep synchroniser with reset value parameter and rise/fall pulse outputs. It is instantiated for sclk and cs_n; mosi uses the data path only.

Test Plan:
- Mode 0, DATA_W=8, tx buffer preloaded 0xA5; host sends 0x3C -> miso shows bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C with rx_valid_o one pulse-train later; tx_ready_o=1 after cs_n falls.
- Modes 1/2/3 with same bytes (0x96 out, 0x5A in) -> identical byte values received/sent; no underrun.
- Two back-to-back words with rx_ready_i held 0 -> first word 0x11 retained, rx_overrun_o single pulse on second word 0x22.
- cs_n asserted with empty TX buffer -> tx_underrun_o pulse, miso=0 for whole word; a write of 0x77 mid-word is sent as the next word.
- cs_n deasserted after 5 bits -> no rx_valid_o, busy_o drops; next transaction receives 0xC3 correctly from bit 0.
- DATA_W=16, CPHA=1: 0xBEEF in, 0x1234 out -> exact match; rst_n pulsed mid-word -> all outputs at reset values asynchronously.
